// File: rtl/fetch_ctrl.sv
// Next-PC stage: owns the PC, drives the instruction memory address and
// registers the fetched word into IF/ID, with a BOOT/RUN/HALTED sequencer.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [31:0]       ifid_instr,
  output logic              ifid_valid,
  output logic              misalign_err,
  output logic              halted
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic              target_misaligned;

  assign pc_plus4          = pc_q + ADDR_W'(4);
  assign target            = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign target_misaligned = |redirect_pc[1:0];

  // PC register only; memory sees no input-to-address path.
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      ifid_pc4     <= '0;
      ifid_instr   <= NOP_INSTR;
      ifid_valid   <= 1'b0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      // A redirect wins in every state, so error tracking is state-independent.
      if (redirect && target_misaligned) begin
        misalign_err <= 1'b1;
      end
      unique case (state_q)
        StBoot: begin
          if (redirect) begin
            pc_q <= target;
          end
          state_q <= StRun;
        end
        StRun: begin
          if (redirect) begin
            pc_q       <= target;
            ifid_pc4   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end else if (stall) begin
            // hold everything
          end else if (halt_req) begin
            ifid_pc4   <= pc_plus4;
            ifid_instr <= imem_data;
            ifid_valid <= 1'b1;
            state_q    <= StHalted;
            halted     <= 1'b1;
          end else begin
            pc_q       <= pc_plus4;
            ifid_pc4   <= pc_plus4;
            ifid_instr <= imem_data;
            ifid_valid <= 1'b1;
          end
        end
        StHalted: begin
          if (redirect) begin
            pc_q       <= target;
            ifid_pc4   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            state_q    <= StRun;
            halted     <= 1'b0;
          end else begin
            ifid_valid <= 1'b0;
          end
        end
        default: begin
          state_q <= StBoot;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed plus randomized bench for fetch_ctrl against a behavioural model
// of the fetch rules, with a synthetic combinational instruction memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misalign_err;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = boot, 1 = run, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_err;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt_req     (halt_req),
    .imem_data    (imem_data),
    .imem_addr    (imem_addr),
    .ifid_pc4     (ifid_pc4),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .misalign_err (misalign_err),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    chk("halted", {31'b0, halted}, {31'b0, m_mode == 2});
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_pc4   = 32'h0;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic bubble();
    m_pc4   = 32'h0;
    m_instr = 32'h0;
    m_valid = 1'b0;
  endtask

  // One rising edge of the fetch rules, using inputs held across the edge.
  task automatic model_edge();
    logic [31:0] tgt;
    tgt = redirect_pc & ~32'h3;
    if (redirect && (redirect_pc % 4 != 0)) m_err = 1'b1;
    if (m_mode == 0) begin
      if (redirect) m_pc = tgt;
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (redirect) begin
        m_pc = tgt;
        bubble();
        m_mode = 1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (redirect) begin
      m_pc = tgt;
      bubble();
    end else if (!stall) begin
      m_instr = mem(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      if (halt_req) m_mode = 2;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input logic [31:0] t);
    int n;
    n = 0;
    while (m_pc != t && n < 64) begin
      cyc();
      n++;
    end
    chk("run_to", imem_addr, t);
  endtask

  initial begin
    model_reset();
    // T1: reset and boot bubble, then sequential fetch
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("t1_boot_addr", imem_addr, 32'h0);
    chk("t1_boot_valid", {31'b0, ifid_valid}, 32'h0);
    cyc();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_pc4", ifid_pc4, 32'h4);
    chk("t1_valid", {31'b0, ifid_valid}, 32'h1);
    cyc();
    cyc();
    chk("t1_addr12", imem_addr, 32'hC);

    // T2: two-cycle stall at 0x10
    run_to(32'h10);
    stall = 1'b1;
    cyc();
    cyc();
    chk("t2_hold", imem_addr, 32'h10);
    chk("t2_pc4", ifid_pc4, 32'h10);
    stall = 1'b0;
    cyc();
    chk("t2_release", imem_addr, 32'h14);

    // T3: redirect overrides stall
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    stall = 1'b0;
    redirect = 1'b0;
    chk("t3_pc", imem_addr, 32'h40);
    chk("t3_flush_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t3_flush_instr", ifid_instr, 32'h0);
    cyc();
    chk("t3_pc4", ifid_pc4, 32'h44);

    // T4: misaligned target is aligned and sticks until reset
    redirect = 1'b1;
    redirect_pc = 32'h43;
    cyc();
    redirect = 1'b0;
    chk("t4_pc", imem_addr, 32'h40);
    chk("t4_err", {31'b0, misalign_err}, 32'h1);
    repeat (10) cyc();
    chk("t4_err_sticky", {31'b0, misalign_err}, 32'h1);
    rst = 1'b1;
    cyc();
    chk("t4_err_cleared", {31'b0, misalign_err}, 32'h0);
    rst = 1'b0;
    cyc();

    // T5: halt at 0x20, then leave via redirect
    run_to(32'h20);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("t5_halted", {31'b0, halted}, 32'h1);
    chk("t5_frozen", imem_addr, 32'h20);
    cyc();
    chk("t5_valid_drop", {31'b0, ifid_valid}, 32'h0);
    chk("t5_still_frozen", imem_addr, 32'h20);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("t5_resume", imem_addr, 32'h100);
    chk("t5_unhalted", {31'b0, halted}, 32'h0);

    // T6: wrap at top of address space, then async reset mid-cycle
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("t6_wrap_pc", imem_addr, 32'h0);
    chk("t6_wrap_pc4", ifid_pc4, 32'h0);
    cyc();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6_async_valid", {31'b0, ifid_valid}, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Randomized traffic
    repeat (500) begin
      redirect    = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      halt_req    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
